// File: rtl/hdmi_pattern_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hdmi_pattern_gen_multi                                     |
// | Description : Multi-mode test-pattern source for the HDMI overlay path.  |
// |               Follows the TX sync/DE timing to track frame, line and     |
// |               pixel position and emits one RGB pixel per clock with       |
// |               sync/DE delayed two clocks to stay aligned.                |
// | Ports       : HDMI_TX_CLK  - pixel clock (rising edge)                   |
// |               reset_n      - synchronous active-low reset                |
// |               HDMI_TX_VS/HS/DE - incoming timing                         |
// |               mode         - pattern select, taken at frame start        |
// |               pause        - hold the frame counter                      |
// |               solid_rgb    - {R,G,B} for the solid pattern               |
// |               ppe_red/green/blue, ppe_de/hs/vs - aligned pixel output    |
// |               frame_cnt    - current frame counter                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hdmi_pattern_gen_multi #(
  parameter int COLOR_W     = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int RAMP_MAX    = 255,
  parameter int CHECK_SHIFT = 4
) (
  input  logic                   HDMI_TX_CLK,
  input  logic                   reset_n,
  input  logic                   HDMI_TX_VS,
  input  logic                   HDMI_TX_HS,
  input  logic                   HDMI_TX_DE,
  input  logic [2:0]             mode,
  input  logic                   pause,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [COLOR_W-1:0]     ppe_red,
  output logic [COLOR_W-1:0]     ppe_green,
  output logic [COLOR_W-1:0]     ppe_blue,
  output logic                   ppe_de,
  output logic                   ppe_hs,
  output logic                   ppe_vs,
  output logic [COLOR_W-1:0]     frame_cnt
);

  // Position counters are wide enough for the active area and for the bits
  // the gradient and checker patterns pick out of them.
  localparam int XB  = $clog2(H_ACTIVE);
  localparam int XB2 = (XB > COLOR_W) ? XB : COLOR_W;
  localparam int XW  = (XB2 > CHECK_SHIFT) ? XB2 : CHECK_SHIFT + 1;
  localparam int YB  = $clog2(V_ACTIVE);
  localparam int YB2 = (YB > COLOR_W) ? YB : COLOR_W;
  localparam int YW  = (YB2 > CHECK_SHIFT) ? YB2 : CHECK_SHIFT + 1;

  localparam logic [XW-1:0]      c_X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]      c_Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [COLOR_W-1:0] c_RAMP_MAX = COLOR_W'(RAMP_MAX);
  localparam logic [COLOR_W-1:0] c_FULL     = '1;

  localparam logic [2:0] c_MODE_SOLID  = 3'd0;
  localparam logic [2:0] c_MODE_RAMP   = 3'd1;
  localparam logic [2:0] c_MODE_BARS   = 3'd2;
  localparam logic [2:0] c_MODE_CHECK  = 3'd3;
  localparam logic [2:0] c_MODE_HGRAD  = 3'd4;
  localparam logic [2:0] c_MODE_VGRAD  = 3'd5;

  // Stage-1 state
  logic              r_de_d1, r_hs_d1, r_vs_d1;
  logic [XW-1:0]     r_x, r_s1_x;
  logic [YW-1:0]     r_y, r_s1_y;
  logic [2:0]        r_bar, r_s1_bar;
  logic [2:0]        r_mode;

  logic              w_frame_start, w_line_end;
  logic [XW-1:0]     w_x_inc;
  logic [7:1]        w_bar_hit;

  assign w_frame_start = r_vs_d1 & ~HDMI_TX_VS;
  assign w_line_end    = r_de_d1 & ~HDMI_TX_DE;
  assign w_x_inc       = (r_x == c_X_LAST) ? r_x : r_x + 1'b1;

  // Bar boundaries are fixed at elaboration; the bar index steps in the
  // same cycle x lands on a boundary so both describe the same pixel.
  for (genvar k = 1; k < 8; k++) begin : g_bar
    assign w_bar_hit[k] = (w_x_inc == XW'(k * H_ACTIVE / 8));
  end

  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      r_de_d1   <= 1'b0;
      r_hs_d1   <= 1'b0;
      r_vs_d1   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_bar     <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_bar  <= '0;
      r_mode    <= c_MODE_SOLID;
      frame_cnt <= '0;
    end else begin
      r_de_d1  <= HDMI_TX_DE;
      r_hs_d1  <= HDMI_TX_HS;
      r_vs_d1  <= HDMI_TX_VS;
      // Stage-1 snapshot holds the position of the pixel on the inputs now.
      r_s1_x   <= r_x;
      r_s1_y   <= r_y;
      r_s1_bar <= r_bar;

      if (w_line_end) begin
        r_x   <= '0;
        r_bar <= '0;
      end else if (HDMI_TX_DE) begin
        r_x <= w_x_inc;
        if (|w_bar_hit) begin
          r_bar <= r_bar + 3'd1;
        end
      end

      // Frame start has priority over the line-end increment of y.
      if (w_frame_start) begin
        r_y    <= '0;
        r_mode <= mode;
        if (!pause) begin
          frame_cnt <= (frame_cnt == c_RAMP_MAX) ? '0 : frame_cnt + 1'b1;
        end
      end else if (w_line_end && (r_y != c_Y_LAST)) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  // Stage-2 pattern selection
  logic [COLOR_W-1:0] w_r, w_g, w_b, w_vgrad, w_ramp_gb;
  logic               w_check;

  assign w_vgrad   = r_s1_y[COLOR_W-1:0] + frame_cnt;
  assign w_ramp_gb = frame_cnt - 1'b1;
  assign w_check   = r_s1_x[CHECK_SHIFT] ^ r_s1_y[CHECK_SHIFT] ^ frame_cnt[0];

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (r_de_d1) begin
      case (r_mode)
        c_MODE_SOLID: begin
          w_r = solid_rgb[3*COLOR_W-1:2*COLOR_W];
          w_g = solid_rgb[2*COLOR_W-1:COLOR_W];
          w_b = solid_rgb[COLOR_W-1:0];
        end
        c_MODE_RAMP: begin
          w_r = frame_cnt;
          w_g = w_ramp_gb;
          w_b = w_ramp_gb;
        end
        c_MODE_BARS: begin
          w_r = {COLOR_W{~r_s1_bar[1]}};
          w_g = {COLOR_W{~r_s1_bar[2]}};
          w_b = {COLOR_W{~r_s1_bar[0]}};
        end
        c_MODE_CHECK: begin
          w_r = w_check ? c_FULL : '0;
          w_g = w_check ? c_FULL : '0;
          w_b = w_check ? c_FULL : '0;
        end
        c_MODE_HGRAD: begin
          w_r = r_s1_x[COLOR_W-1:0];
          w_g = r_s1_x[COLOR_W-1:0];
          w_b = r_s1_x[COLOR_W-1:0];
        end
        c_MODE_VGRAD: begin
          w_r = w_vgrad;
          w_g = w_vgrad;
          w_b = w_vgrad;
        end
        default: begin
          w_r = '0;
          w_g = '0;
          w_b = '0;
        end
      endcase
    end
  end

  always_ff @(posedge HDMI_TX_CLK) begin
    if (!reset_n) begin
      ppe_red   <= '0;
      ppe_green <= '0;
      ppe_blue  <= '0;
      ppe_de    <= 1'b0;
      ppe_hs    <= 1'b0;
      ppe_vs    <= 1'b0;
    end else begin
      ppe_red   <= w_r;
      ppe_green <= w_g;
      ppe_blue  <= w_b;
      ppe_de    <= r_de_d1;
      ppe_hs    <= r_hs_d1;
      ppe_vs    <= r_vs_d1;
    end
  end

  // Upper position bits only matter for counting, not for any pattern.
  logic w_unused;
  assign w_unused = ^{r_s1_x, r_s1_y};

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hdmi_pattern_gen_multi                                  |
// | Description : Self-checking bench for hdmi_pattern_gen_multi. Expected   |
// |               output words are queued as stimulus is driven and compared |
// |               two clocks later against ppe_* outputs.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hdmi_pattern_gen_multi;

  localparam int CW  = 8;
  localparam int H   = 64;
  localparam int V   = 20;
  localparam int RM  = 255;
  localparam int CS  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vs, hs, de;
  logic [2:0]    mode;
  logic          pause;
  logic [23:0]   solid_rgb;
  logic [7:0]    ppe_red, ppe_green, ppe_blue, frame_cnt;
  logic          ppe_de, ppe_hs, ppe_vs;

  int checks   = 0;
  int failures = 0;
  string tag   = "init";

  // Reference state of the spec model
  int          m_x, m_y;
  logic [7:0]  m_fc;
  logic [2:0]  m_mode;
  logic        m_pde, m_pvs;
  logic [26:0] q[$];

  always #5 clk = ~clk;

  hdmi_pattern_gen_multi #(
    .COLOR_W(CW), .H_ACTIVE(H), .V_ACTIVE(V), .RAMP_MAX(RM), .CHECK_SHIFT(CS)
  ) dut (
    .HDMI_TX_CLK(clk), .reset_n(reset_n),
    .HDMI_TX_VS(vs), .HDMI_TX_HS(hs), .HDMI_TX_DE(de),
    .mode(mode), .pause(pause), .solid_rgb(solid_rgb),
    .ppe_red(ppe_red), .ppe_green(ppe_green), .ppe_blue(ppe_blue),
    .ppe_de(ppe_de), .ppe_hs(ppe_hs), .ppe_vs(ppe_vs),
    .frame_cnt(frame_cnt)
  );

  function automatic logic [23:0] pat(input logic [2:0] md, input int x, input int y,
                                      input logic [7:0] fc);
    int         b;
    logic [7:0] v;
    logic [7:0] gb;
    case (md)
      3'd0: return solid_rgb;
      3'd1: begin
        gb = fc - 8'd1;
        return {fc, gb, gb};
      end
      3'd2: begin
        b = x / (H / 8);
        if (b > 7) b = 7;
        return {((b & 2) != 0) ? 8'h00 : 8'hFF,
                ((b & 4) != 0) ? 8'h00 : 8'hFF,
                ((b & 1) != 0) ? 8'h00 : 8'hFF};
      end
      3'd3: return (((((x >> CS) ^ (y >> CS)) & 1) ^ int'(fc[0])) != 0) ? 24'hFFFFFF : 24'h0;
      3'd4: begin
        v = 8'(x);
        return {v, v, v};
      end
      3'd5: begin
        v = 8'(y + int'(fc));
        return {v, v, v};
      end
      default: return 24'h0;
    endcase
  endfunction

  task automatic step(input logic d, input logic h, input logic v);
    logic [26:0] e;
    logic [23:0] px;
    logic        fs, le;
    de = d; hs = h; vs = v;
    if (!reset_n) begin
      q.push_back(27'h0);
      m_x = 0; m_y = 0; m_fc = 8'd0; m_mode = 3'd0; m_pde = 1'b0; m_pvs = 1'b0;
    end else begin
      px = d ? pat(m_mode, m_x, m_y, m_fc) : 24'h0;
      q.push_back({d, h, v, px});
      fs = m_pvs & ~v;
      le = m_pde & ~d;
      if (le) m_x = 0;
      else if (d && m_x < H - 1) m_x = m_x + 1;
      if (fs) begin
        m_y = 0;
        m_mode = mode;
        if (!pause) m_fc = (m_fc == 8'(RM)) ? 8'd0 : m_fc + 8'd1;
      end else if (le && m_y < V - 1) begin
        m_y = m_y + 1;
      end
      m_pde = d;
      m_pvs = v;
    end
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (!reset_n) e = 27'h0;
      checks++;
      assert ({ppe_de, ppe_hs, ppe_vs, ppe_red, ppe_green, ppe_blue} === e)
      else begin
        failures++;
        $error("FAIL %s pixel obs=%h exp=%h", tag,
               {ppe_de, ppe_hs, ppe_vs, ppe_red, ppe_green, ppe_blue}, e);
      end
    end
  endtask

  task automatic check_fc(input logic [7:0] exp);
    checks++;
    assert (frame_cnt === exp)
    else begin
      failures++;
      $error("FAIL %s frame_cnt obs=%0d exp=%0d", tag, frame_cnt, exp);
    end
  endtask

  task automatic blank(input int n, input logic v);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, v);
  endtask

  task automatic line(input int npix, input logic v);
    step(1'b0, 1'b1, v);
    step(1'b0, 1'b1, v);
    blank(2, v);
    for (int i = 0; i < npix; i++) step(1'b1, 1'b0, v);
    blank(2, v);
  endtask

  task automatic vs_fall();
    blank(2, 1'b1);
    blank(2, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    mode = 3'd1; pause = 1'b0; solid_rgb = 24'hA1B2C3;

    // Reset held with DE toggling
    tag = "reset";
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    assert ({ppe_de, ppe_hs, ppe_vs, ppe_red, ppe_green, ppe_blue, frame_cnt} === 35'h0)
    else begin
      failures++;
      $error("FAIL reset_outputs obs=%h exp=0",
             {ppe_de, ppe_hs, ppe_vs, ppe_red, ppe_green, ppe_blue, frame_cnt});
    end
    reset_n = 1'b1;

    // First frame in ramp mode: R=1, G=B=0
    tag = "ramp_first";
    vs_fall();
    check_fc(8'd1);
    line(8, 1'b0);

    // Run the counter to its wrap point
    tag = "ramp_run";
    for (int f = 0; f < 254; f++) begin
      vs_fall();
      check_fc(m_fc);
      line(4, 1'b0);
    end
    check_fc(8'd255);
    tag = "ramp_wrap";
    vs_fall();
    check_fc(8'd0);
    line(4, 1'b0);

    // Pause holds the counter
    tag = "pause";
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      vs_fall();
      check_fc(8'd0);
      line(4, 1'b0);
    end
    pause = 1'b0;

    // Colour bars, plus an over-long line to reach x saturation
    tag = "bars";
    mode = 3'd2;
    vs_fall();
    line(H, 1'b0);
    line(H + 3, 1'b0);

    // Checkerboard across the y=16 boundary, then the inverted frame
    tag = "checker_even";
    mode = 3'd3;
    vs_fall();
    check_fc(8'd2);
    for (int l = 0; l < 18; l++) line(H, 1'b0);
    tag = "checker_odd";
    vs_fall();
    for (int l = 0; l < 18; l++) line(H, 1'b0);

    // Mid-frame mode request is deferred to the next frame start
    tag = "solid_then_hgrad";
    mode = 3'd0;
    solid_rgb = 24'h123456;
    vs_fall();
    line(H, 1'b0);
    mode = 3'd4;
    line(H, 1'b0);
    tag = "hgrad";
    vs_fall();
    line(H + 2, 1'b0);

    // Vertical gradient with y saturation
    tag = "vgrad";
    mode = 3'd5;
    vs_fall();
    for (int l = 0; l < V + 2; l++) line(4, 1'b0);

    // VS fall coincident with DE fall: y restarts at 0
    tag = "vs_de_coincide";
    step(1'b0, 1'b1, 1'b1);
    blank(2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    blank(2, 1'b0);
    line(4, 1'b0);
    line(4, 1'b0);

    // Reserved mode gives black
    tag = "mode6";
    mode = 3'd6;
    vs_fall();
    line(6, 1'b0);

    // Reset in the middle of an active line
    tag = "midline_reset";
    mode = 3'd2;
    vs_fall();
    step(1'b0, 1'b1, 1'b0);
    blank(2, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check_fc(8'd0);
    reset_n = 1'b1;
    tag = "after_reset";
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    blank(2, 1'b0);
    line(H, 1'b0);
    tag = "bars_after_reset";
    vs_fall();
    check_fc(8'd1);
    line(H, 1'b0);
    blank(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_pattern_gen_multi.md
Name: hdmi_pattern_gen_multi

Overview:
Parametrised, multi-mode test-pattern source for the HDMI overlay path, replacing the per-frame ramp generator. Runs on the pixel clock and tracks frame, line and pixel position from the TX sync/DE timing. Produces one RGB pixel per clock plus sync/DE delayed to match. Modes are solid, legacy frame ramp, colour bars, checkerboard, horizontal gradient and scrolling vertical gradient.

Parameters:
COLOR_W, 8, bits per colour channel
H_ACTIVE, 640, active pixels per line (multiple of 8)
V_ACTIVE, 480, active lines per frame
RAMP_MAX, 255, frame counter wrap value (≤ 2^COLOR_W-1)
CHECK_SHIFT, 4, checker square size = 2^CHECK_SHIFT pixels

Ports:
HDMI_TX_CLK  in  1  pixel clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
HDMI_TX_VS  in  1  vertical sync, synchronous to HDMI_TX_CLK
HDMI_TX_HS  in  1  horizontal sync
HDMI_TX_DE  in  1  data enable, high during active pixels
mode  in  3  requested pattern; sampled at frame start only
pause  in  1  1 = hold frame counter
solid_rgb  in  3*COLOR_W  {R,G,B} for SOLID mode
ppe_red  out  COLOR_W  red
ppe_green  out  COLOR_W  green
ppe_blue  out  COLOR_W  blue
ppe_de  out  1  HDMI_TX_DE delayed 2 clocks
ppe_hs  out  1  HDMI_TX_HS delayed 2 clocks
ppe_vs  out  1  HDMI_TX_VS delayed 2 clocks
frame_cnt  out  COLOR_W  current frame counter

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, x/y/frame counters 0, active mode 0 (SOLID), edge-detect registers 0. Reset mid-frame: outputs 0 until the first DE after release; the pattern uses x=y=0 from release until the next frame start.
- Frame start = VS falling edge (VS registered; detect prev=1, cur=0). At frame start: active_mode <= mode; y <= 0; frame_cnt <= (frame_cnt==RAMP_MAX) ? 0 : frame_cnt+1, unless pause=1 (hold). mode changes mid-frame are ignored until the next frame start.
- x counter: +1 per clock with DE=1, saturating at H_ACTIVE-1; cleared on DE falling edge. y: +1 on each DE falling edge, saturating at V_ACTIVE-1.
- bar_idx (0..7): cleared with x; +1 when x reaches k*H_ACTIVE/8 for k=1..7 (elaboration-time constants, no divider).
- Pattern by active_mode. F = full scale (all ones):
  0 SOLID: solid_rgb fields.
  1 FRAME_RAMP: R=frame_cnt, G=B=frame_cnt-1 mod 2^COLOR_W (legacy behaviour).
  2 COLOR_BARS: R=~bar_idx[1], G=~bar_idx[2], B=~bar_idx[0], each bit expanded to F/0. Order: white, yellow, cyan, green, magenta, red, blue, black.
  3 CHECKER: (x[CHECK_SHIFT] ^ y[CHECK_SHIFT] ^ frame_cnt[0]) ? F : 0 on all channels.
  4 H_GRAD: R=G=B = x[COLOR_W-1:0] (wraps).
  5 V_GRAD: R=G=B = (y + frame_cnt) mod 2^COLOR_W.
  6,7: black.
- Latency: stage 1 registers position and DE/HS/VS; stage 2 registers RGB and ppe_*. Pixel at input DE cycle n appears on outputs at n+2. Output RGB = 0 whenever delayed DE=0.
- Simultaneous VS fall and DE fall: y resets to 0 (frame start wins).
- frame_cnt wrap: RAMP_MAX → 0 on the next frame start; never exceeds RAMP_MAX.

Test Plan:
- Reset held 3 clocks with DE toggling → all outputs 0; after release and a VS fall with mode=1, frame_cnt=1, ppe_red=1, ppe_green=ppe_blue=0 on DE pixels.
- mode=1, 256 frames, pause=0 → frame_cnt runs 1..255 then 0; at frame_cnt=0, ppe_green=ppe_blue=255. With pause=1 for 3 frames, frame_cnt holds.
- mode=2, one 640-pixel line → x=0..79 white (255,255,255); x=80 yellow (255,255,0); x=560..639 black. First pixel appears 2 clocks after DE rise.
- mode=3, CHECK_SHIFT=4, frame_cnt even → x=0..15 y=0 black; x=16 white; line y=16 inverted. Next frame fully inverted.
- Change mode 0→4 mid-frame → output stays solid_rgb until the next VS fall, then gradient with ppe_red = x mod 256.
- Assert reset_n=0 mid-line, release → outputs 0 during reset; active mode reverts to SOLID until the next frame start; ppe_de/hs/vs track inputs with 2-clock delay.
